// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of tone_in, qualifies it against a 21-note table
// and emits one note-RAM write per beat. Build option: TONE_DECODER_ADDR_STOP_EN.
module tone_decoder #(
  parameter int unsigned BEAT_CYCLES = 2500000,
  parameter int unsigned TOL_SHIFT   = 6
) (
  input  logic        clk_10m,
  input  logic        reset,
  input  logic        tone_in,
  output logic [11:0] note_code,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [11:0] wr_data,
  output logic        full
);

  localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_TC = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Nominal periods in clk_10m cycles: low 1..7, med 1..7, high 1..7.
  localparam logic [15:0] NOM [21] = '{
    16'd38168, 16'd34014, 16'd30303, 16'd28653, 16'd25510, 16'd22727, 16'd20243,
    16'd19120, 16'd17036, 16'd15175, 16'd14327, 16'd12755, 16'd11364, 16'd10121,
    16'd9560,  16'd8511,  16'd7587,  16'd7158,  16'd6378,  16'd5682,  16'd5061
  };

  function automatic logic [11:0] match_note(input logic [16:0] p);
    logic [11:0] code;
    logic [16:0] nom;
    logic [16:0] tol;
    logic [16:0] diff;
    code = '0;
    for (int i = 0; i < 21; i++) begin
      nom  = {1'b0, NOM[i]};
      tol  = nom >> TOL_SHIFT;
      diff = (p > nom) ? (p - nom) : (nom - p);
      if (diff <= tol) code = 12'((i % 7) + 1) << (4 * (i / 7));
    end
    return code;
  endfunction

  logic              sync1_q, sync2_q, prev_q;
  logic [15:0]       cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic [11:0]       m_q, m_d;
  logic              m_vld_q, m_vld_d;
  logic [11:0]       cand_q, cand_d;
  logic [11:0]       cur_q, cur_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [5:0]        addr_q, addr_d;
  logic              edge_det, timeout, beat_tc, wr_en_c;
`ifdef TONE_DECODER_ADDR_STOP_EN
  logic              full_q, full_d;
`endif

  always_comb begin
    edge_det = sync2_q & ~prev_q;
    timeout  = (cnt_q == CNT_MAX);
    beat_tc  = (beat_q == BEAT_TC);

    cnt_d   = edge_det ? 16'd0 : (timeout ? cnt_q : cnt_q + 16'd1);
    // An unarmed edge only restarts the counter; no period is produced.
    armed_d = edge_det ? 1'b1 : (timeout ? 1'b0 : armed_q);
    m_vld_d = edge_det & armed_q;
    m_d     = m_q;
    if (edge_det && armed_q) m_d = match_note({1'b0, cnt_q} + 17'd1);

    cand_d = cand_q;
    cur_d  = cur_q;
    if (timeout) begin
      cand_d = '0;
      cur_d  = '0;
    end else if (m_vld_q) begin
      if (m_q == cand_q) cur_d = m_q;
      cand_d = m_q;
    end

    beat_d = beat_tc ? '0 : beat_q + BEAT_W'(1);

`ifdef TONE_DECODER_ADDR_STOP_EN
    wr_en_c = beat_tc & ~full_q;
    full_d  = full_q | (wr_en_c & (addr_q == 6'd63));
    addr_d  = (wr_en_c && (addr_q != 6'd63)) ? addr_q + 6'd1 : addr_q;
`else
    wr_en_c = beat_tc;
    addr_d  = wr_en_c ? addr_q + 6'd1 : addr_q;
`endif
  end

  always_ff @(posedge clk_10m or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      m_q     <= '0;
      m_vld_q <= 1'b0;
      cand_q  <= '0;
      cur_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
`ifdef TONE_DECODER_ADDR_STOP_EN
      full_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= tone_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      m_q     <= m_d;
      m_vld_q <= m_vld_d;
      cand_q  <= cand_d;
      cur_q   <= cur_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
`ifdef TONE_DECODER_ADDR_STOP_EN
      full_q  <= full_d;
`endif
    end
  end

  // wr_data samples cur_q before any same-cycle update lands.
  assign note_code = cur_q;
  assign wr_en     = wr_en_c;
  assign wr_addr   = addr_q;
  assign wr_data   = wr_en_c ? cur_q : 12'h000;
`ifdef TONE_DECODER_ADDR_STOP_EN
  assign full      = full_q;
`else
  assign full      = 1'b0;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: period-list note model checked every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_tone_decoder;

  localparam int BEAT = 1500;
`ifdef TONE_DECODER_ADDR_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk_10m = 1'b0;
  logic        reset   = 1'b1;
  logic        tone_in = 1'b0;
  logic [11:0] note_code, wr_data;
  logic        wr_en, full;
  logic [5:0]  wr_addr;

  int tests = 0;
  int fails = 0;

  always #50 clk_10m = ~clk_10m;

  tone_decoder #(.BEAT_CYCLES(BEAT), .TOL_SHIFT(6)) dut (
    .clk_10m  (clk_10m),
    .reset    (reset),
    .tone_in  (tone_in),
    .note_code(note_code),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .full     (full)
  );

  int nom_tab [21] = '{38168, 34014, 30303, 28653, 25510, 22727, 20243,
                       19120, 17036, 15175, 14327, 12755, 11364, 10121,
                       9560,  8511,  7587,  7158,  6378,  5682,  5061};

  function automatic logic [11:0] classify(int p);
    int n;
    int dif;
    for (int o = 0; o < 3; o++) begin
      for (int d = 0; d < 7; d++) begin
        n   = nom_tab[o*7 + d];
        dif = (p > n) ? (p - n) : (n - p);
        if (dif <= n / 64) return 12'(d + 1) << (4 * o);
      end
    end
    return 12'h000;
  endfunction

  // Model: list of period codes since reset/timeout; the reported note is the latest code
  // that repeated back-to-back. Visible three cycles after the bench samples the rising edge.
  int          k, last_rise, writes;
  bit          prev_s, armed;
  logic [11:0] codes [$];
  logic [11:0] dly [3];
  logic [11:0] exp_note = '0, exp_data = '0;
  logic        exp_wr_en = 1'b0, exp_full = 1'b0;
  logic [5:0]  exp_addr = '0;

  function automatic logic [11:0] qualified();
    for (int i = codes.size() - 1; i >= 1; i--)
      if (codes[i] == codes[i-1]) return codes[i];
    return 12'h000;
  endfunction

  always @(posedge clk_10m or negedge reset) begin
    if (!reset) begin
      k = 0; last_rise = -2; writes = 0; prev_s = 1'b0; armed = 1'b0;
      codes.delete(); codes.push_back(12'h000);
      for (int i = 0; i < 3; i++) dly[i] = 12'h000;
      exp_note = '0; exp_data = '0; exp_wr_en = 1'b0; exp_full = 1'b0; exp_addr = '0;
    end else begin
      k++;
      if (exp_wr_en) writes++;
      exp_note = dly[2];
      dly[2] = dly[1];
      dly[1] = dly[0];
      if (tone_in && !prev_s) begin
        if (armed) codes.push_back(classify(k - last_rise));
        armed = 1'b1;
        last_rise = k;
      end else if (k - last_rise == 65535) begin
        codes.delete(); codes.push_back(12'h000);
        armed = 1'b0;
      end
      prev_s = tone_in;
      dly[0] = qualified();
      exp_full  = STOP && (writes >= 64);
      exp_addr  = exp_full ? 6'd63 : 6'(writes % 64);
      exp_wr_en = ((k % BEAT) == BEAT - 1) && !exp_full;
      exp_data  = exp_wr_en ? exp_note : 12'h000;
    end
  end

  always @(negedge clk_10m) begin
    tests++;
    if (note_code !== exp_note || wr_en !== exp_wr_en || wr_addr !== exp_addr ||
        wr_data !== exp_data || full !== exp_full) begin
      fails++;
      if (fails <= 20)
        $display("FAIL model_cmp t=%0t note=%h req %h wr_en=%b req %b addr=%0d req %0d data=%h req %h full=%b req %b",
                 $time, note_code, exp_note, wr_en, exp_wr_en, wr_addr, exp_addr, wr_data, exp_data, full, exp_full);
    end
  end

  // Write monitor: address log up to the mid-run reset, last written data, 1976 Hz glitch watch.
  logic [5:0]  addr_log [$];
  bit          log_en = 1'b1;
  logic [11:0] last_wr_data = 12'hFFF;
  bit          watch_mid = 1'b0, bad_mid = 1'b0;

  always @(negedge clk_10m) begin
    if (wr_en) begin
      last_wr_data = wr_data;
      if (log_en) addr_log.push_back(wr_addr);
    end
    if (watch_mid && note_code != 12'h030 && note_code != 12'h700) bad_mid = 1'b1;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_note"}, note_code, 12'h000);
    check({name, "_wr_en"}, {11'd0, wr_en}, 12'h000);
    check({name, "_addr"}, {6'd0, wr_addr}, 12'h000);
    check({name, "_data"}, wr_data, 12'h000);
    check({name, "_full"}, {11'd0, full}, 12'h000);
  endtask

  task automatic tone(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      tone_in = 1'b1;
      repeat (period / 2) @(negedge clk_10m);
      tone_in = 1'b0;
      repeat (period - period / 2) @(negedge clk_10m);
    end
  endtask

  initial begin
    bit addr_ok;
    #5 reset = 1'b0;
    repeat (4) @(negedge clk_10m);
    check_zero_outputs("reset0");
    reset = 1'b1;

    tone(22727, 3);                       // 440 Hz
    check("a4_note", note_code, 12'h006);
    check("a4_wr_data", last_wr_data, 12'h006);

    tone(15175, 3);                       // 659 Hz
    check("e5_note", note_code, 12'h030);

    watch_mid = 1'b1;
    tone(5061, 3);                        // 1976 Hz
    watch_mid = 1'b0;
    check("b6_note", note_code, 12'h700);
    check("b6_no_glitch", {11'd0, bad_mid}, 12'h000);

    // Address sequence over the first 65 beats (all within the run so far).
    check("addr0", {6'd0, addr_log[0]}, 12'h000);
    check("addr63", {6'd0, addr_log[63]}, 12'd63);
    addr_ok = 1'b1;
    for (int i = 0; i < addr_log.size() && i < 65; i++)
      if (addr_log[i] != (STOP ? 6'(i) : 6'(i % 64))) addr_ok = 1'b0;
    check("addr_seq", {11'd0, addr_ok}, 12'h001);
    if (STOP) begin
      check("stop_count", 12'(addr_log.size()), 12'd64);
      check("stop_full", {11'd0, full}, 12'h001);
    end else begin
      check("wrap_addr64", {6'd0, addr_log[64]}, 12'h000);
      check("full_tied", {11'd0, full}, 12'h000);
    end

    // Reset mid-note: outputs clear without waiting for a clock.
    log_en = 1'b0;
    @(negedge clk_10m);
    #10 reset = 1'b0;
    #1 check("async_clear", note_code, 12'h000);
    repeat (3) @(negedge clk_10m);
    check_zero_outputs("reset1");
    reset = 1'b1;

    tone(19120, 3);                       // 523 Hz
    check("c5_note", note_code, 12'h010);

    repeat (65535 + 2 * BEAT) @(negedge clk_10m);
    check("timeout_note", note_code, 12'h000);
    check("timeout_wr_data", last_wr_data, 12'h000);

    tone(21739, 3);                       // 460 Hz, outside tolerance
    check("off_note", note_code, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
